// File: rtl/stack_hs.sv
// LIFO stack engine with a valid/ready command port and a one-entry buffered response port.
// The top entry is kept in a register alongside the count so the `top_o` output needs no array read.
module stack_hs #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
   parameter int AF_THRESH  = DEPTH - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [2:0]            cmd_op_i,
   input  logic [DATA_WIDTH-1:0] cmd_data_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  rsp_err_o,
   input  logic                  err_clr_i,
   output logic [DATA_WIDTH-1:0] top_o,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  err_ovf_o,
   output logic                  err_udf_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_NOP     = 3'b000,
      OP_PUSH    = 3'b001,
      OP_POP     = 3'b010,
      OP_REPLACE = 3'b011,
      OP_DUP     = 3'b100,
      OP_SWAP    = 3'b101,
      OP_PEEK    = 3'b110,
      OP_CLEAR   = 3'b111
   } op_e;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [DATA_WIDTH-1:0] top_q, top_d;
   logic                  rspValid_q, rspValid_d;
   logic [DATA_WIDTH-1:0] rspData_q, rspData_d;
   logic                  rspErr_q, rspErr_d;
   logic                  errOvf_q, errOvf_d;
   logic                  errUdf_q, errUdf_d;

   op_e                   opCode;
   logic                  accept;
   logic                  isFull, isEmpty, twoPlus;
   logic [IDX_W-1:0]      idxFree, idxTop, idxNext;
   logic                  setOvf, setUdf;
   logic                  wrEnA, wrEnB;
   logic [IDX_W-1:0]      wrIdxA, wrIdxB;
   logic [DATA_WIDTH-1:0] wrDataA, wrDataB;

   assign opCode      = op_e'(cmd_op_i);
   assign cmd_ready_o = !rspValid_q || rsp_ready_i;
   assign accept      = cmd_valid_i && cmd_ready_o;

   assign isFull  = (count_q == CNT_WIDTH'(DEPTH));
   assign isEmpty = (count_q == '0);
   assign twoPlus = (count_q >= CNT_WIDTH'(2));

   // Index arithmetic wraps modulo 2^IDX_W, which is harmless because results are only used when guarded by count.
   assign idxFree = count_q[IDX_W-1:0];
   assign idxTop  = idxFree - IDX_W'(1);
   assign idxNext = idxFree - IDX_W'(2);

   // Command decode: next stack state, array write ports, response buffer and error flags.
   always_comb begin
      count_d    = count_q;
      top_d      = top_q;
      rspValid_d = rspValid_q && !rsp_ready_i;
      rspData_d  = rspData_q;
      rspErr_d   = rspErr_q;
      setOvf     = 1'b0;
      setUdf     = 1'b0;
      wrEnA      = 1'b0;
      wrIdxA     = idxFree;
      wrDataA    = cmd_data_i;
      wrEnB      = 1'b0;
      wrIdxB     = idxNext;
      wrDataB    = top_q;

      if (accept) begin
         case (opCode)
            OP_PUSH: begin
               if (isFull) begin
                  setOvf = 1'b1;
               end else begin
                  wrEnA   = 1'b1;
                  count_d = count_q + CNT_WIDTH'(1);
                  top_d   = cmd_data_i;
               end
            end
            OP_POP, OP_REPLACE, OP_PEEK: begin
               rspValid_d = 1'b1;
               if (isEmpty) begin
                  setUdf    = 1'b1;
                  rspData_d = '0;
                  rspErr_d  = 1'b1;
               end else begin
                  rspData_d = top_q;
                  rspErr_d  = 1'b0;
                  if (opCode == OP_POP) begin
                     count_d = count_q - CNT_WIDTH'(1);
                     top_d   = twoPlus ? mem_q[idxNext] : '0;
                  end else if (opCode == OP_REPLACE) begin
                     wrEnA  = 1'b1;
                     wrIdxA = idxTop;
                     top_d  = cmd_data_i;
                  end
               end
            end
            OP_DUP: begin
               if (isEmpty) begin
                  setUdf = 1'b1;
               end else if (isFull) begin
                  setOvf = 1'b1;
               end else begin
                  wrEnA   = 1'b1;
                  wrDataA = top_q;
                  count_d = count_q + CNT_WIDTH'(1);
               end
            end
            OP_SWAP: begin
               if (!twoPlus) begin
                  setUdf = 1'b1;
               end else begin
                  wrEnA   = 1'b1;
                  wrIdxA  = idxTop;
                  wrDataA = mem_q[idxNext];
                  wrEnB   = 1'b1;
                  top_d   = mem_q[idxNext];
               end
            end
            OP_CLEAR: begin
               count_d = '0;
               top_d   = '0;
            end
            default: begin
            end
         endcase
      end

      errOvf_d = setOvf || (errOvf_q && !err_clr_i);
      errUdf_d = setUdf || (errUdf_q && !err_clr_i);
   end

   // Entry storage carries no reset; an empty stack is defined by the count alone.
   always_ff @(posedge clk) begin
      if (wrEnA) mem_q[wrIdxA] <= wrDataA;
      if (wrEnB) mem_q[wrIdxB] <= wrDataB;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         top_q      <= '0;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
         rspErr_q   <= 1'b0;
         errOvf_q   <= 1'b0;
         errUdf_q   <= 1'b0;
      end else begin
         count_q    <= count_d;
         top_q      <= top_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
         rspErr_q   <= rspErr_d;
         errOvf_q   <= errOvf_d;
         errUdf_q   <= errUdf_d;
      end
   end

   assign rsp_valid_o   = rspValid_q;
   assign rsp_data_o    = rspData_q;
   assign rsp_err_o     = rspErr_q;
   assign top_o         = top_q;
   assign count_o       = count_q;
   assign full_o        = isFull;
   assign empty_o       = isEmpty;
   assign almost_full_o = (int'(count_q) >= AF_THRESH);
   assign err_ovf_o     = errOvf_q;
   assign err_udf_o     = errUdf_q;

endmodule

// File: tb/tb_stack_hs.sv
// Directed-vector bench for stack_hs: the stimulus queues hand-computed responses,
// and an independent monitor pops and compares each one as the DUT hands it over.
module tb_stack_hs;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_REPLACE = 3'b011;
   localparam logic [2:0] OP_DUP     = 3'b100;
   localparam logic [2:0] OP_SWAP    = 3'b101;
   localparam logic [2:0] OP_PEEK    = 3'b110;
   localparam logic [2:0] OP_CLEAR   = 3'b111;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmdValid;
   logic          cmdReady;
   logic [2:0]    cmdOp;
   logic [DW-1:0] cmdData;
   logic          rspValid;
   logic          rspReady;
   logic [DW-1:0] rspData;
   logic          rspErr;
   logic          errClr;
   logic [DW-1:0] top;
   logic [CW-1:0] count;
   logic          full, empty, almostFull, errOvf, errUdf;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   rsp_t expQ[$];
   rsp_t expHead;
   int   nVectors     = 0;
   int   nMiscompares = 0;

   always #5 clk = ~clk;

   stack_hs #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid_i  (cmdValid),
      .cmd_ready_o  (cmdReady),
      .cmd_op_i     (cmdOp),
      .cmd_data_i   (cmdData),
      .rsp_valid_o  (rspValid),
      .rsp_ready_i  (rspReady),
      .rsp_data_o   (rspData),
      .rsp_err_o    (rspErr),
      .err_clr_i    (errClr),
      .top_o        (top),
      .count_o      (count),
      .full_o       (full),
      .empty_o      (empty),
      .almost_full_o(almostFull),
      .err_ovf_o    (errOvf),
      .err_udf_o    (errUdf)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one command; queue its expected response once the handshake is seen.
   task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] data,
                                input bit expRsp, input logic [DW-1:0] expData, input logic expErr);
      int waited = 0;
      cmdOp    = op;
      cmdData  = data;
      cmdValid = 1'b1;
      while (!cmdReady) begin
         @(posedge clk); #1;
         waited++;
         if (waited > 20) begin
            checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
            cmdValid = 1'b0;
            return;
         end
      end
      if (expRsp) expQ.push_back({expData, expErr});
      @(posedge clk); #1;
      cmdValid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulseErrClr();
      errClr = 1'b1;
      @(posedge clk); #1;
      errClr = 1'b0;
   endtask

   // Monitor: mid-cycle, a valid response with ready high is consumed at the next edge.
   always @(negedge clk) begin
      if (rst_n && rspValid && rspReady) begin
         if (expQ.size() == 0) begin
            checkOutput("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            expHead = expQ.pop_front();
            checkOutput("rsp_data", 32'(rspData), 32'(expHead.data));
            checkOutput("rsp_err", 32'(rspErr), 32'(expHead.err));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b1;
      cmdValid = 1'b0;
      cmdOp    = OP_NOP;
      cmdData  = '0;
      rspReady = 1'b1;
      errClr   = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_empty", 32'(empty), 32'd1);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_af", 32'(almostFull), 32'd0);
      checkOutput("reset_top", 32'(top), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset_rsp_data", 32'(rspData), 32'd0);
      checkOutput("reset_rsp_err", 32'(rspErr), 32'd0);
      checkOutput("reset_ovf", 32'(errOvf), 32'd0);
      checkOutput("reset_udf", 32'(errUdf), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("reset_cmd_ready", 32'(cmdReady), 32'd1);

      // Basic LIFO order with back-to-back pops.
      applyStimulus(OP_PUSH, 8'h11, 0, 8'h00, 1'b0);
      applyStimulus(OP_PUSH, 8'h22, 0, 8'h00, 1'b0);
      applyStimulus(OP_PUSH, 8'h33, 0, 8'h00, 1'b0);
      checkOutput("push3_count", 32'(count), 32'd3);
      checkOutput("push3_top", 32'(top), 32'h33);
      applyStimulus(OP_POP, 8'h00, 1, 8'h33, 1'b0);
      checkOutput("pop1_valid", 32'(rspValid), 32'd1);
      applyStimulus(OP_POP, 8'h00, 1, 8'h22, 1'b0);
      checkOutput("pop2_valid", 32'(rspValid), 32'd1);
      applyStimulus(OP_POP, 8'h00, 1, 8'h11, 1'b0);
      checkOutput("pop3_valid", 32'(rspValid), 32'd1);
      checkOutput("pop3_empty", 32'(empty), 32'd1);
      checkOutput("pop3_top", 32'(top), 32'd0);
      idle(1);
      checkOutput("drained_valid", 32'(rspValid), 32'd0);

      // Fill to capacity, then overflow.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(OP_PUSH, 8'(i), 0, 8'h00, 1'b0);
         if (i == 12) checkOutput("af_below_thresh", 32'(almostFull), 32'd0);
         if (i == 13) checkOutput("af_at_thresh", 32'(almostFull), 32'd1);
         if (i == 14) checkOutput("full_at_15", 32'(full), 32'd0);
      end
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_count", 32'(count), 32'd16);
      checkOutput("fill_top", 32'(top), 32'h0F);
      applyStimulus(OP_PUSH, 8'hAA, 0, 8'h00, 1'b0);
      checkOutput("ovf_flag", 32'(errOvf), 32'd1);
      checkOutput("ovf_count", 32'(count), 32'd16);
      checkOutput("ovf_top", 32'(top), 32'h0F);
      pulseErrClr();
      checkOutput("ovf_cleared", 32'(errOvf), 32'd0);
      errClr = 1'b1;
      applyStimulus(OP_DUP, 8'h00, 0, 8'h00, 1'b0);
      errClr = 1'b0;
      checkOutput("ovf_set_beats_clr", 32'(errOvf), 32'd1);
      checkOutput("dup_full_count", 32'(count), 32'd16);
      applyStimulus(OP_CLEAR, 8'h00, 0, 8'h00, 1'b0);
      checkOutput("clear_count", 32'(count), 32'd0);
      checkOutput("clear_top", 32'(top), 32'd0);
      checkOutput("clear_af", 32'(almostFull), 32'd0);
      checkOutput("clear_no_udf", 32'(errUdf), 32'd0);
      pulseErrClr();

      // Underflow cases.
      applyStimulus(OP_POP, 8'h00, 1, 8'h00, 1'b1);
      applyStimulus(OP_PEEK, 8'h00, 1, 8'h00, 1'b1);
      checkOutput("udf_flag", 32'(errUdf), 32'd1);
      checkOutput("udf_count", 32'(count), 32'd0);
      pulseErrClr();
      checkOutput("udf_cleared", 32'(errUdf), 32'd0);
      applyStimulus(OP_PUSH, 8'h42, 0, 8'h00, 1'b0);
      applyStimulus(OP_SWAP, 8'h00, 0, 8'h00, 1'b0);
      checkOutput("swap1_udf", 32'(errUdf), 32'd1);
      checkOutput("swap1_count", 32'(count), 32'd1);
      checkOutput("swap1_top", 32'(top), 32'h42);
      pulseErrClr();
      applyStimulus(OP_CLEAR, 8'h00, 0, 8'h00, 1'b0);

      // Stack manipulation: [N=07, T=05] -> swap, dup, replace, peek, drain.
      applyStimulus(OP_PUSH, 8'h07, 0, 8'h00, 1'b0);
      applyStimulus(OP_PUSH, 8'h05, 0, 8'h00, 1'b0);
      applyStimulus(OP_SWAP, 8'h00, 0, 8'h00, 1'b0);
      checkOutput("swap_top", 32'(top), 32'h07);
      checkOutput("swap_count", 32'(count), 32'd2);
      applyStimulus(OP_DUP, 8'h00, 0, 8'h00, 1'b0);
      checkOutput("dup_count", 32'(count), 32'd3);
      checkOutput("dup_top", 32'(top), 32'h07);
      applyStimulus(OP_REPLACE, 8'h09, 1, 8'h07, 1'b0);
      checkOutput("replace_top", 32'(top), 32'h09);
      checkOutput("replace_count", 32'(count), 32'd3);
      applyStimulus(OP_PEEK, 8'h00, 1, 8'h09, 1'b0);
      applyStimulus(OP_POP, 8'h00, 1, 8'h09, 1'b0);
      applyStimulus(OP_POP, 8'h00, 1, 8'h07, 1'b0);
      applyStimulus(OP_POP, 8'h00, 1, 8'h05, 1'b0);
      checkOutput("manip_empty", 32'(empty), 32'd1);
      checkOutput("manip_no_err", 32'({errOvf, errUdf}), 32'd0);

      // Response stall holds cmd_ready low and ignores pending commands.
      applyStimulus(OP_PUSH, 8'h3C, 0, 8'h00, 1'b0);
      applyStimulus(OP_PUSH, 8'h5A, 0, 8'h00, 1'b0);
      rspReady = 1'b0;
      applyStimulus(OP_POP, 8'h00, 1, 8'h5A, 1'b0);
      checkOutput("stall_valid", 32'(rspValid), 32'd1);
      cmdValid = 1'b1;
      cmdOp    = OP_PUSH;
      cmdData  = 8'hEE;
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall_cmd_ready", 32'(cmdReady), 32'd0);
         checkOutput("stall_rsp_data", 32'(rspData), 32'h5A);
         checkOutput("stall_count", 32'(count), 32'd1);
         @(posedge clk); #1;
      end
      cmdValid = 1'b0;
      rspReady = 1'b1;
      #1;
      checkOutput("release_cmd_ready", 32'(cmdReady), 32'd1);
      @(posedge clk); #1;
      checkOutput("release_valid", 32'(rspValid), 32'd0);
      checkOutput("release_top", 32'(top), 32'h3C);

      // Asynchronous reset discards a pending response.
      applyStimulus(OP_PUSH, 8'h01, 0, 8'h00, 1'b0);
      applyStimulus(OP_PUSH, 8'h02, 0, 8'h00, 1'b0);
      applyStimulus(OP_PUSH, 8'h03, 0, 8'h00, 1'b0);
      rspReady = 1'b0;
      applyStimulus(OP_PEEK, 8'h00, 0, 8'h00, 1'b0);
      checkOutput("pre_rst_count", 32'(count), 32'd4);
      checkOutput("pre_rst_valid", 32'(rspValid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_count", 32'(count), 32'd0);
      checkOutput("midrst_valid", 32'(rspValid), 32'd0);
      checkOutput("midrst_rsp_data", 32'(rspData), 32'd0);
      checkOutput("midrst_top", 32'(top), 32'd0);
      checkOutput("midrst_empty", 32'(empty), 32'd1);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      rspReady = 1'b1;
      idle(1);
      checkOutput("postrst_valid", 32'(rspValid), 32'd0);
      applyStimulus(OP_PUSH, 8'h77, 0, 8'h00, 1'b0);
      applyStimulus(OP_PEEK, 8'h00, 1, 8'h77, 1'b0);
      idle(2);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
